buffer_readout_sequencer: RTL



---
 rtl/buffer_readout_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/buffer_readout_sequencer.sv
// buffer_readout_sequencer: reads each completed bank of the ping-pong sample RAM
// in address order and streams the words out over valid/ready.
// Ports: clk/rst (async active-high); buffer_ready_i/bank_i request a bank;
//   rd_en_o/rd_addr_o/rd_data_i form the RAM read port (1-cycle latency);
//   m_data_o/m_valid_o/m_ready_i/m_last_o form the output stream;
//   busy_o, overrun_o (sticky, cleared by clear_overrun_i), frame_cnt_o status.
// Optional feature: define READOUT_HEADER_EN to prefix every frame with a
//   header word {8'hA5, frame_cnt_o}, left-aligned and zero-padded.
module buffer_readout_sequencer #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 24,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buffer_ready_i,
  input  logic              bank_i,
  output logic              rd_en_o,
  output logic [ADDR_W:0]   rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              overrun_o,
  input  logic              clear_overrun_i,
  output logic [15:0]       frame_cnt_o
);

`ifdef READOUT_HEADER_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, READ = 2'd2, FLUSH = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd2, FLUSH = 2'd3} state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q;
  logic                bank_q;
  logic                pend_q, pend_bank_q;
  logic                rd_pend_q;   // a read issued last cycle; its data is on rd_data_i now
  logic                rd_last_q;   // ...and it was index DEPTH-1
  logic                overrun_q;
  logic [15:0]         frame_cnt_q;

  // Two-entry skid FIFO; the head entry drives the stream directly.
  logic [DATA_W-1:0]   head_dat_q, tail_dat_q;
  logic                head_last_q, tail_last_q;
  logic                head_vld_q, tail_vld_q;

  logic                pop, push, push_last, start, start_bank, rd_en, hdr_load, overrun_set;
  logic [DATA_W-1:0]   push_dat;
  logic [1:0]          used;

  assign pop = head_vld_q & m_ready_i;

  // Words already committed to the FIFO (in flight + stored), net of the word
  // leaving this cycle: the slot being popped is free for a read issued now,
  // which keeps one word per cycle with m_ready_i held high.
  assign used = {1'b0, rd_pend_q} + {1'b0, head_vld_q} + {1'b0, tail_vld_q} - {1'b0, pop};

  assign overrun_set = buffer_ready_i & (state_q != IDLE);
  // A fresh pulse in IDLE is the newest request and supersedes any pending one.
  assign start_bank  = buffer_ready_i ? bank_i : pend_bank_q;

`ifdef READOUT_HEADER_EN
  logic [DATA_W-1:0] hdr_word;
  assign hdr_word  = DATA_W'({8'hA5, frame_cnt_q}) << (DATA_W - 24);
  assign push      = rd_pend_q | hdr_load;
  assign push_dat  = hdr_load ? hdr_word : rd_data_i;
  assign push_last = hdr_load ? 1'b0 : rd_last_q;
`else
  assign push      = rd_pend_q | hdr_load;
  assign push_dat  = rd_data_i;
  assign push_last = rd_last_q;
`endif

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    rd_en    = 1'b0;
    hdr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (buffer_ready_i || pend_q) begin
          start = 1'b1;
`ifdef READOUT_HEADER_EN
          hdr_load = 1'b1;   // FIFO is always empty in IDLE
          state_d  = HDR;
`else
          state_d  = READ;
`endif
        end
      end
`ifdef READOUT_HEADER_EN
      HDR: begin
        if (pop) state_d = READ;
      end
`endif
      READ: begin
        rd_en = (used < 2'd2);
        if (rd_en && idx_q == ADDR_W'(DEPTH - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        if (pop && head_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      bank_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_en;
      rd_last_q <= rd_en && (idx_q == ADDR_W'(DEPTH - 1));
      if (start) begin
        bank_q <= start_bank;
        idx_q  <= '0;
      end else if (rd_en) begin
        idx_q <= idx_q + ADDR_W'(1);
      end
      if (overrun_set) begin
        pend_q      <= 1'b1;
        pend_bank_q <= bank_i;
      end else if (start) begin
        pend_q <= 1'b0;
      end
      if (overrun_set)          overrun_q <= 1'b1;
      else if (clear_overrun_i) overrun_q <= 1'b0;
      if (pop && head_last_q) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // FIFO update. The read-issue rule guarantees no push while full without a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_dat_q  <= '0;
      tail_dat_q  <= '0;
      head_last_q <= 1'b0;
      tail_last_q <= 1'b0;
      head_vld_q  <= 1'b0;
      tail_vld_q  <= 1'b0;
    end else if (pop) begin
      if (tail_vld_q) begin
        head_dat_q  <= tail_dat_q;
        head_last_q <= tail_last_q;
        tail_vld_q  <= push;
        if (push) begin
          tail_dat_q  <= push_dat;
          tail_last_q <= push_last;
        end
      end else begin
        head_vld_q <= push;
        if (push) begin
          head_dat_q  <= push_dat;
          head_last_q <= push_last;
        end
      end
    end else if (push) begin
      if (!head_vld_q) begin
        head_vld_q  <= 1'b1;
        head_dat_q  <= push_dat;
        head_last_q <= push_last;
      end else begin
        tail_vld_q  <= 1'b1;
        tail_dat_q  <= push_dat;
        tail_last_q <= push_last;
      end
    end
  end

  assign rd_en_o     = rd_en;
  assign rd_addr_o   = {bank_q, idx_q};
  assign m_data_o    = head_dat_q;
  assign m_valid_o   = head_vld_q;
  assign m_last_o    = head_vld_q & head_last_q;
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = overrun_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
